// File: rtl/frogger_pkg.sv
// frogger_pkg: definitions shared by the frog controller and its helpers.
//   frog_state_t : controller FSM states
//   GRID_W       : number of columns in a lane row
//   LIVES_INIT   : lives after reset
//   col_onehot() : one-hot row image for a column index
package frogger_pkg;

    localparam int unsigned GRID_W     = 16;
    localparam int unsigned LIVES_INIT = 3;

    typedef enum logic [1:0] {
        PLAY   = 2'd0,
        FREEZE = 2'd1,
        WIN    = 2'd2,
        OVER   = 2'd3
    } frog_state_t;

    function automatic logic [GRID_W-1:0] col_onehot(input logic [3:0] col);
        logic [GRID_W-1:0] img;
        img      = '0;
        img[col] = 1'b1;
        return img;
    endfunction

endpackage

// File: rtl/btn_edge.sv
// btn_edge: registered rising-edge detector for one synchronised key level.
//   clk   : system clock
//   reset : asynchronous, active-low reset
//   key   : key level, active-high
//   pulse : one-cycle registered pulse per rising edge of key
module btn_edge (
    input  logic clk,
    input  logic reset,
    input  logic key,
    output logic pulse
);

    logic prev;
    logic armed;

    // armed stays low for the first cycle after reset so that a key already
    // held while reset is released is absorbed into prev instead of being
    // reported as an edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev  <= 1'b0;
            armed <= 1'b0;
            pulse <= 1'b0;
        end else begin
            prev  <= key;
            armed <= 1'b1;
            pulse <= armed & key & ~prev;
        end
    end

endmodule

// File: rtl/frog_ctrl.sv
// frog_ctrl: frog position, lives and game-state controller.
//   clk         : system clock, rising edge
//   reset       : asynchronous, active-low reset
//   up/down/left/right : synchronised key levels, active-high
//   lane_pixels : car pixels of the row at frog_row (bit i = column i)
//   frog_row    : current row, 0 = goal, 15 = start
//   frog_col    : current column
//   frog_pixels : one-hot image of the frog column, zero in OVER
//   lives       : remaining lives
//   crash       : one-cycle pulse per collision
//   hit         : high in OVER
//   win         : high in WIN
module frog_ctrl
    import frogger_pkg::*;
#(
    parameter int unsigned HOLD_WIDTH = 10,
    parameter int unsigned START_ROW  = 15,
    parameter int unsigned START_COL  = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              up,
    input  logic              down,
    input  logic              left,
    input  logic              right,
    input  logic [GRID_W-1:0] lane_pixels,
    output logic [3:0]        frog_row,
    output logic [3:0]        frog_col,
    output logic [GRID_W-1:0] frog_pixels,
    output logic [1:0]        lives,
    output logic              crash,
    output logic              hit,
    output logic              win
);

    localparam logic [3:0] ROW0  = 4'(START_ROW);
    localparam logic [3:0] COL0  = 4'(START_COL);
    localparam logic [1:0] LIVES0 = 2'(LIVES_INIT);

    logic up_p, down_p, left_p, right_p;

    btn_edge u_edge_up    (.clk(clk), .reset(reset), .key(up),    .pulse(up_p));
    btn_edge u_edge_down  (.clk(clk), .reset(reset), .key(down),  .pulse(down_p));
    btn_edge u_edge_left  (.clk(clk), .reset(reset), .key(left),  .pulse(left_p));
    btn_edge u_edge_right (.clk(clk), .reset(reset), .key(right), .pulse(right_p));

    frog_state_t           state_q, state_n;
    logic [3:0]            row_q, row_n;
    logic [3:0]            col_q, col_n;
    logic [1:0]            lives_q, lives_n;
    logic [HOLD_WIDTH-1:0] cnt_q, cnt_n;
    logic                  crash_q, crash_n;
    logic                  hit_q, hit_n;
    logic                  win_q, win_n;
    logic [GRID_W-1:0]     pix_q, pix_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= PLAY;
            row_q   <= ROW0;
            col_q   <= COL0;
            lives_q <= LIVES0;
            cnt_q   <= '0;
            crash_q <= 1'b0;
            hit_q   <= 1'b0;
            win_q   <= 1'b0;
            pix_q   <= col_onehot(COL0);
        end else begin
            state_q <= state_n;
            row_q   <= row_n;
            col_q   <= col_n;
            lives_q <= lives_n;
            cnt_q   <= cnt_n;
            crash_q <= crash_n;
            hit_q   <= hit_n;
            win_q   <= win_n;
            pix_q   <= pix_n;
        end
    end

    always_comb begin
        state_n = state_q;
        row_n   = row_q;
        col_n   = col_q;
        lives_n = lives_q;
        cnt_n   = cnt_q;
        crash_n = 1'b0;
        hit_n   = hit_q;
        win_n   = win_q;

        unique case (state_q)
            PLAY: begin
                // Collision outranks reaching the goal, which outranks a move.
                if (lane_pixels[col_q]) begin
                    state_n = FREEZE;
                    crash_n = 1'b1;
                    cnt_n   = '0;
                    if (lives_q != 2'd0) begin
                        lives_n = lives_q - 1'b1;
                    end
                end else if (row_q == 4'd0) begin
                    state_n = WIN;
                    win_n   = 1'b1;
                end else if (up_p) begin
                    if (row_q != 4'd0) row_n = row_q - 1'b1;
                end else if (down_p) begin
                    if (row_q != 4'd15) row_n = row_q + 1'b1;
                end else if (left_p) begin
                    if (col_q != 4'd0) col_n = col_q - 1'b1;
                end else if (right_p) begin
                    if (col_q != 4'd15) col_n = col_q + 1'b1;
                end
            end
            FREEZE: begin
                cnt_n = cnt_q + 1'b1;
                if (cnt_q == '1) begin
                    if (lives_q == 2'd0) begin
                        state_n = OVER;
                        hit_n   = 1'b1;
                    end else begin
                        state_n = PLAY;
                        row_n   = ROW0;
                        col_n   = COL0;
                    end
                end
            end
            WIN, OVER: begin
            end
            default: begin
            end
        endcase

        pix_n = (state_n == OVER) ? '0 : col_onehot(col_n);
    end

    assign frog_row    = row_q;
    assign frog_col    = col_q;
    assign frog_pixels = pix_q;
    assign lives       = lives_q;
    assign crash       = crash_q;
    assign hit         = hit_q;
    assign win         = win_q;

endmodule

// File: tb/tb_frog_ctrl.sv
// tb_frog_ctrl: directed, table-driven bench for frog_ctrl (short freeze).
module tb_frog_ctrl;

    localparam int unsigned HW = 4;

    logic        clk;
    logic        reset;
    logic        up, down, left, right;
    logic [15:0] lane_pixels;
    logic [3:0]  frog_row, frog_col;
    logic [15:0] frog_pixels;
    logic [1:0]  lives;
    logic        crash, hit, win;

    int checks;
    int failures;

    frog_ctrl #(.HOLD_WIDTH(HW), .START_ROW(15), .START_COL(7)) dut (
        .clk(clk), .reset(reset),
        .up(up), .down(down), .left(left), .right(right),
        .lane_pixels(lane_pixels),
        .frog_row(frog_row), .frog_col(frog_col), .frog_pixels(frog_pixels),
        .lives(lives), .crash(crash), .hit(hit), .win(win)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       u, d, l, r;
        logic [3:0] row, col;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic st(input string tag, input logic [3:0] r, input logic [3:0] c,
                      input logic [15:0] pix, input logic [1:0] lv,
                      input logic cr, input logic ht, input logic wn);
        chk({tag, ".row"},   32'(frog_row),    32'(r));
        chk({tag, ".col"},   32'(frog_col),    32'(c));
        chk({tag, ".pix"},   32'(frog_pixels), 32'(pix));
        chk({tag, ".lives"}, 32'(lives),       32'(lv));
        chk({tag, ".crash"}, 32'(crash),       32'(cr));
        chk({tag, ".hit"},   32'(hit),         32'(ht));
        chk({tag, ".win"},   32'(win),         32'(wn));
    endtask

    // One press: key high for one cycle, low for one; the move is visible afterwards.
    task automatic press(input int k);
        case (k)
            0: up = 1'b1;
            1: down = 1'b1;
            2: left = 1'b1;
            default: right = 1'b1;
        endcase
        @(negedge clk);
        up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0;
        @(negedge clk);
    endtask

    function automatic vec_t mk(input logic [3:0] keys, input logic [3:0] r, input logic [3:0] c);
        vec_t v;
        v.u = keys[3]; v.d = keys[2]; v.l = keys[1]; v.r = keys[0];
        v.row = r; v.col = c;
        return v;
    endfunction

    function automatic logic [15:0] img(input logic [3:0] c);
        logic [15:0] one;
        one = 16'h0001;
        return one << c;
    endfunction

    initial begin
        checks = 0; failures = 0;
        // keys {u,d,l,r}, expected row/col after one clock
        tbl[0]  = mk(4'b1000, 15, 7);
        tbl[1]  = mk(4'b1000, 14, 7);
        tbl[2]  = mk(4'b1000, 14, 7);
        tbl[3]  = mk(4'b0000, 14, 7);
        tbl[4]  = mk(4'b1001, 14, 7);
        tbl[5]  = mk(4'b0000, 13, 7);
        tbl[6]  = mk(4'b0000, 13, 7);
        tbl[7]  = mk(4'b0100, 13, 7);
        tbl[8]  = mk(4'b0000, 14, 7);
        tbl[9]  = mk(4'b0001, 14, 7);
        tbl[10] = mk(4'b0000, 14, 8);
        tbl[11] = mk(4'b0011, 14, 8);
        tbl[12] = mk(4'b0000, 14, 7);
        tbl[13] = mk(4'b0110, 14, 7);
        tbl[14] = mk(4'b0000, 15, 7);
        tbl[15] = mk(4'b0100, 15, 7);
        tbl[16] = mk(4'b0000, 15, 7);

        reset = 1'b0; up = 0; down = 0; left = 0; right = 0; lane_pixels = '0;
        #12;
        st("reset", 15, 7, 16'h0080, 3, 0, 0, 0);
        @(negedge clk); reset = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 17; i++) begin
            up = tbl[i].u; down = tbl[i].d; left = tbl[i].l; right = tbl[i].r;
            @(negedge clk);
            st($sformatf("vec%0d", i), tbl[i].row, tbl[i].col, img(tbl[i].col), 3, 0, 0, 0);
        end
        up = 0; down = 0; left = 0; right = 0;

        // Left to the edge, eighth press dropped.
        repeat (7) press(2);
        chk("left7.col", 32'(frog_col), 0);
        press(2);
        st("left8", 15, 0, 16'h0001, 3, 0, 0, 0);
        repeat (16) press(3);
        st("right_sat", 15, 15, 16'h8000, 3, 0, 0, 0);
        repeat (8) press(2);
        chk("back.col", 32'(frog_col), 7);

        // Crash 1 away from the start position; keys ignored while frozen.
        press(0); press(3);
        st("pre_crash1", 14, 8, 16'h0100, 3, 0, 0, 0);
        lane_pixels = 16'h0100;
        @(negedge clk);
        st("crash1", 14, 8, 16'h0100, 2, 1, 0, 0);
        lane_pixels = '0;
        @(negedge clk);
        chk("crash1.pulse_end", 32'(crash), 0);
        press(0);
        repeat (12) @(negedge clk);
        st("freeze1_last", 14, 8, 16'h0100, 2, 0, 0, 0);
        @(negedge clk);
        st("respawn1", 15, 7, 16'h0080, 2, 0, 0, 0);
        press(0);
        chk("play_again.row", 32'(frog_row), 14);
        press(1);

        // Crash 2 arriving together with an up edge: move ignored.
        up = 1'b1;
        @(negedge clk);
        up = 1'b0; lane_pixels = 16'h0080;
        @(negedge clk);
        st("crash2", 15, 7, 16'h0080, 1, 1, 0, 0);
        lane_pixels = '0;
        repeat (16) @(negedge clk);
        st("respawn2", 15, 7, 16'h0080, 1, 0, 0, 0);

        // Crash 3 with one life: FREEZE then OVER.
        lane_pixels = 16'h0080;
        @(negedge clk);
        st("crash3", 15, 7, 16'h0080, 0, 1, 0, 0);
        lane_pixels = '0;
        repeat (15) @(negedge clk);
        chk("freeze3.hit", 32'(hit), 0);
        @(negedge clk);
        st("over", 15, 7, 16'h0000, 0, 0, 1, 0);
        lane_pixels = 16'hFFFF;
        press(0); press(2);
        st("over_hold", 15, 7, 16'h0000, 0, 0, 1, 0);
        lane_pixels = '0;

        // Asynchronous reset with a key held across release.
        up = 1'b1;
        reset = 1'b0;
        #1;
        st("reset2", 15, 7, 16'h0080, 3, 0, 0, 0);
        @(negedge clk); reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("held_key.row", 32'(frog_row), 15);
        up = 1'b0;
        repeat (2) @(negedge clk);
        chk("held_key_rel.row", 32'(frog_row), 15);

        // Walk to the goal.
        repeat (14) press(0);
        chk("row1", 32'(frog_row), 1);
        press(0);
        st("goal", 0, 7, 16'h0080, 3, 0, 0, 0);
        @(negedge clk);
        st("win", 0, 7, 16'h0080, 3, 0, 0, 1);
        lane_pixels = 16'hFFFF;
        press(1); press(3);
        st("win_hold", 0, 7, 16'h0080, 3, 0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
